// File: rtl/sobel_mem_arbiter_if.sv
// Handshake and frame-RAM bus shared by the pixel writer, the Sobel reader and the arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface sobel_mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 15,
  parameter int PIXEL_WIDTH = 8
);
  logic                   wr_req_i;
  logic [ADDR_WIDTH-1:0]  wr_addr_i;
  logic [PIXEL_WIDTH-1:0] wr_data_i;
  logic                   wr_gnt_o;
  logic                   rd_req_i;
  logic [ADDR_WIDTH-1:0]  rd_addr_i;
  logic                   rd_gnt_o;
  logic [PIXEL_WIDTH-1:0] rd_data_o;
  logic                   rd_valid_o;
  logic                   mem_en_o;
  logic                   mem_we_o;
  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic [PIXEL_WIDTH-1:0] mem_wdata_o;
  logic [PIXEL_WIDTH-1:0] mem_rdata_i;
  logic                   busy_o;

  modport slave (
    input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
    output wr_gnt_o, rd_gnt_o, rd_data_o, rd_valid_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport master (
    output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
    input  wr_gnt_o, rd_gnt_o, rd_data_o, rd_valid_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/sobel_mem_arbiter.sv
// Single-port frame-RAM arbiter: grayscale writer vs Sobel window reader, bursty round-robin.
// Define SOBEL_ARB_RD_PRIORITY_EN to let reads win contention and ignore the burst limit.
//
// state  | meaning
// IDLE   | no owner, last cycle had no grant
// OWN_WR | writer owns the port, burst_cnt counts its consecutive grants
// OWN_RD | reader owns the port, burst_cnt counts its consecutive grants
module sobel_mem_arbiter #(
  parameter int ADDR_WIDTH  = 15,
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_BURST   = 9
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  sobel_mem_arbiter_if.slave bus
);

`ifdef SOBEL_ARB_RD_PRIORITY_EN
  localparam bit RD_PRIORITY = 1'b1;
`else
  localparam bit RD_PRIORITY = 1'b0;
`endif

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_WR = 2'd1,
    OWN_RD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   last_rd_q, last_rd_d;
  logic                   wr_gnt, rd_gnt;
  logic                   at_limit;

  logic                   mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [PIXEL_WIDTH-1:0] mem_wdata_q;
  logic [2:0]             rd_pipe_q;
  logic [PIXEL_WIDTH-1:0] rd_data_q;

  assign at_limit = (cnt_q == MAX_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;

    // Grants are combinational, so hold them off while reset is asserted
    if (nreset_i) begin
      unique case (state_q)
        IDLE: begin
          if (bus.wr_req_i && bus.rd_req_i) begin
            if (RD_PRIORITY || !last_rd_q) rd_gnt = 1'b1;
            else                           wr_gnt = 1'b1;
          end else begin
            wr_gnt = bus.wr_req_i;
            rd_gnt = bus.rd_req_i;
          end
        end
        OWN_WR: begin
          if (bus.wr_req_i && (!at_limit || !bus.rd_req_i)) wr_gnt = 1'b1;
          else if (bus.rd_req_i)                            rd_gnt = 1'b1;
        end
        OWN_RD: begin
          if (bus.rd_req_i && (RD_PRIORITY || !at_limit || !bus.wr_req_i)) rd_gnt = 1'b1;
          else if (bus.wr_req_i)                                           wr_gnt = 1'b1;
        end
        default: ;
      endcase
    end

    if (wr_gnt) begin
      last_rd_d = 1'b0;
      if (state_q == OWN_WR) begin
        cnt_d = at_limit ? 4'd1 : cnt_q + 4'd1;
      end else begin
        state_d = OWN_WR;
        cnt_d   = 4'd1;
      end
    end else if (rd_gnt) begin
      last_rd_d = 1'b1;
      if (state_q == OWN_RD) begin
        cnt_d = at_limit ? 4'd1 : cnt_q + 4'd1;
      end else begin
        state_d = OWN_RD;
        cnt_d   = 4'd1;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_rd_q   <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pipe_q   <= 3'b000;
      rd_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      mem_en_q  <= wr_gnt | rd_gnt;
      mem_we_q  <= wr_gnt;
      if (wr_gnt) begin
        mem_addr_q  <= bus.wr_addr_i;
        mem_wdata_q <= bus.wr_data_i;
      end else if (rd_gnt) begin
        mem_addr_q  <= bus.rd_addr_i;
      end
      // pipe[0]: RAM access cycle, pipe[1]: RAM data valid, pipe[2]: rd_data_o valid
      rd_pipe_q <= {rd_pipe_q[1:0], rd_gnt};
      if (rd_pipe_q[1]) rd_data_q <= bus.mem_rdata_i;
    end
  end

  assign bus.wr_gnt_o    = wr_gnt;
  assign bus.rd_gnt_o    = rd_gnt;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_pipe_q[2];
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_mem_arbiter.sv
// Self-checking bench for sobel_mem_arbiter: directed scenarios plus randomized traffic
// scored against a behavioural arbitration/RAM model.
module tb_sobel_mem_arbiter;
  localparam int AW   = 15;
  localparam int PW   = 8;
  localparam int MAXB = 9;
  localparam int NONE = 0;
  localparam int WR   = 1;
  localparam int RD   = 2;
`ifdef SOBEL_ARB_RD_PRIORITY_EN
  localparam bit RD_PRIO = 1'b1;
`else
  localparam bit RD_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  sobel_mem_arbiter_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) bus ();

  sobel_mem_arbiter #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .MAX_BURST(MAXB)) dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .bus      (bus)
  );

  // Synchronous frame RAM
  logic [PW-1:0] ram [0:(1<<AW)-1];
  logic [PW-1:0] ram_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              ram_rdata <= ram[bus.mem_addr_o];
    end
  end
  assign bus.mem_rdata_i = ram_rdata;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner, length of its current run of grants, last grantee
  typedef struct {
    int            cyc;
    logic [PW-1:0] data;
  } rd_exp_t;

  logic [PW-1:0] ref_mem [0:(1<<AW)-1];
  rd_exp_t       rq[$];
  rd_exp_t       re;
  int            m_owner, m_run, m_last, mg, cyc;
  bit            own_r, oth_r, lim, exp_v;
  bit            m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_wdata;

  initial begin
    m_owner = NONE; m_run = 0; m_last = RD; cyc = 0;
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
  end

  always @(negedge clk) begin
    if (!nreset) begin
      m_owner = NONE; m_run = 0; m_last = RD; m_en = 0; m_we = 0;
      rq.delete();
      check("rst_wr_gnt", 32'(bus.wr_gnt_o), 32'd0);
      check("rst_rd_gnt", 32'(bus.rd_gnt_o), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
      check("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
    end else begin
      if (m_owner == NONE) begin
        if (bus.wr_req_i && bus.rd_req_i) mg = (RD_PRIO || m_last == WR) ? RD : WR;
        else if (bus.wr_req_i)            mg = WR;
        else if (bus.rd_req_i)            mg = RD;
        else                              mg = NONE;
      end else begin
        own_r = (m_owner == WR) ? bus.wr_req_i : bus.rd_req_i;
        oth_r = (m_owner == WR) ? bus.rd_req_i : bus.wr_req_i;
        lim   = oth_r && (m_run % MAXB == 0) && !(RD_PRIO && m_owner == RD);
        if (own_r && !lim) mg = m_owner;
        else if (oth_r)    mg = (m_owner == WR) ? RD : WR;
        else               mg = NONE;
      end
      check("wr_gnt", 32'(bus.wr_gnt_o), 32'(mg == WR));
      check("rd_gnt", 32'(bus.rd_gnt_o), 32'(mg == RD));
      check("busy", 32'(bus.busy_o), 32'(m_owner != NONE));
      check("mem_en", 32'(bus.mem_en_o), 32'(m_en));
      check("mem_we", 32'(bus.mem_we_o), 32'(m_we));
      if (m_en) check("mem_addr", 32'(bus.mem_addr_o), 32'(m_addr));
      if (m_we) check("mem_wdata", 32'(bus.mem_wdata_o), 32'(m_wdata));
      exp_v = (rq.size() > 0) && (rq[0].cyc + 3 == cyc);
      check("rd_valid", 32'(bus.rd_valid_o), 32'(exp_v));
      if (exp_v) begin
        check("rd_data", 32'(bus.rd_data_o), 32'(rq[0].data));
        void'(rq.pop_front());
      end

      if (mg == NONE)         begin m_owner = NONE; m_run = 0; end
      else if (mg == m_owner) m_run++;
      else                    begin m_owner = mg; m_run = 1; end
      if (mg != NONE) m_last = mg;
      m_en = (mg != NONE);
      m_we = (mg == WR);
      if (mg == WR) begin
        m_addr  = bus.wr_addr_i;
        m_wdata = bus.wr_data_i;
        ref_mem[bus.wr_addr_i] = bus.wr_data_i;
      end else if (mg == RD) begin
        m_addr  = bus.rd_addr_i;
        re.cyc  = cyc;
        re.data = ref_mem[bus.rd_addr_i];
        rq.push_back(re);
      end
    end
    cyc++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.wr_req_i = 1'b0;
    bus.rd_req_i = 1'b0;
  endtask

  function automatic int gnt_code();
    return bus.wr_gnt_o ? WR : (bus.rd_gnt_o ? RD : NONE);
  endfunction

  int  g, vcnt, rd_cnt, wr_at, wp, rp;
  bit  wg, rg, drop_wr, next_rd;

  initial begin
    bus.wr_req_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rd_req_i = 1'b0; bus.rd_addr_i = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = PW'(i * 37 + 11);
      ref_mem[i] = PW'(i * 37 + 11);
    end
    ram[15'h0100]     = 8'h3C;
    ref_mem[15'h0100] = 8'h3C;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_we", 32'(bus.mem_we_o), 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    check("reset_mem_wdata", 32'(bus.mem_wdata_o), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data_o), 32'd0);
    tick();
    nreset = 1'b1;

    // Single write
    tick();
    bus.wr_req_i = 1'b1; bus.wr_addr_i = 15'h0042; bus.wr_data_i = 8'hA5;
    @(negedge clk);
    check("t1_wr_gnt", 32'(bus.wr_gnt_o), 32'd1);
    tick();
    bus.wr_req_i = 1'b0;
    @(negedge clk);
    check("t1_mem_en", 32'(bus.mem_en_o), 32'd1);
    check("t1_mem_we", 32'(bus.mem_we_o), 32'd1);
    check("t1_mem_addr", 32'(bus.mem_addr_o), 32'h42);
    check("t1_mem_wdata", 32'(bus.mem_wdata_o), 32'hA5);

    // Single read, data 3 cycles after grant
    tick();
    bus.rd_req_i = 1'b1; bus.rd_addr_i = 15'h0100;
    @(negedge clk);
    check("t2_rd_gnt", 32'(bus.rd_gnt_o), 32'd1);
    tick();
    bus.rd_req_i = 1'b0;
    @(negedge clk);
    check("t2_valid_t1", 32'(bus.rd_valid_o), 32'd0);
    @(negedge clk);
    check("t2_valid_t2", 32'(bus.rd_valid_o), 32'd0);
    @(negedge clk);
    check("t2_valid_t3", 32'(bus.rd_valid_o), 32'd1);
    check("t2_data_t3", 32'(bus.rd_data_o), 32'h3C);

    // Contention straight out of reset: 9 writes then 9 reads, no gaps
    tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    bus.wr_req_i = 1'b1; bus.rd_req_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      g = gnt_code();
      check($sformatf("t3_grant%0d", i), 32'(g), 32'((i < 9) ? WR : RD));
      tick();
      if (g == WR) begin bus.wr_addr_i = AW'($urandom_range(0, 63)); bus.wr_data_i = PW'($urandom); end
      if (g == RD) bus.rd_addr_i = AW'($urandom_range(0, 63));
    end
    idle_reqs();
    repeat (5) @(negedge clk);

    // 9-read window, write raised at read 3
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      bus.rd_req_i  = (i < 9);
      bus.rd_addr_i = AW'(i);
      if (i == 2) begin bus.wr_req_i = 1'b1; bus.wr_addr_i = 15'h0030; bus.wr_data_i = 8'h77; end
      if (i == 10) bus.wr_req_i = 1'b0;
      @(negedge clk);
      if (bus.rd_valid_o) vcnt++;
      if (i < 10) check($sformatf("t4_grant%0d", i), 32'(gnt_code()), 32'((i < 9) ? RD : WR));
    end
    check("t4_valid_pulses", 32'(vcnt), 32'd9);

    // Reset after 4 read grants
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.rd_req_i = 1'b1; bus.rd_addr_i = AW'(20 + i);
      @(negedge clk);
    end
    tick();
    nreset = 1'b0;
    bus.rd_req_i = 1'b0;
    #1;
    check("t5_now_mem_en", 32'(bus.mem_en_o), 32'd0);
    check("t5_now_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    check("t5_now_busy", 32'(bus.busy_o), 32'd0);
    check("t5_now_rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check("t5_now_rd_data", 32'(bus.rd_data_o), 32'd0);
    repeat (2) tick();
    nreset = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_valid_o) vcnt++;
    end
    check("t5_no_stale_valid", 32'(vcnt), 32'd0);
    tick();
    bus.wr_req_i = 1'b1; bus.rd_req_i = 1'b1; bus.wr_addr_i = 15'h0005; bus.rd_addr_i = 15'h0006;
    @(negedge clk);
    check("t5_first_contention", 32'(gnt_code()), 32'(WR));
    tick();
    bus.wr_req_i = 1'b0;
    @(negedge clk);
    check("t5_rd_after_wr", 32'(gnt_code()), 32'(RD));
    tick();
    idle_reqs();
    repeat (4) @(negedge clk);

    // Long read run with a write pending from the second cycle
    rd_cnt = 0; wr_at = -1; drop_wr = 0; next_rd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (next_rd) bus.rd_addr_i = AW'(rd_cnt);
      bus.rd_req_i = (rd_cnt < 20);
      if (drop_wr) bus.wr_req_i = 1'b0;
      if (i == 1) begin bus.wr_req_i = 1'b1; bus.wr_addr_i = 15'h0010; bus.wr_data_i = 8'h5A; end
      @(negedge clk);
      next_rd = bus.rd_gnt_o;
      if (bus.rd_gnt_o) rd_cnt++;
      drop_wr = bus.wr_gnt_o;
      if (bus.wr_gnt_o && wr_at < 0) wr_at = i;
    end
    check("t6_read_count", 32'(rd_cnt), 32'd20);
    check("t6_write_cycle", 32'(wr_at), RD_PRIO ? 32'd20 : 32'd9);
    tick();
    idle_reqs();
    repeat (4) @(negedge clk);

    // Randomized traffic; requesters hold request and payload until granted
    wg = 0; rg = 0;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin wp = 90; rp = 90; end
        1:       begin wp = 30; rp = 80; end
        2:       begin wp = 80; rp = 30; end
        default: begin wp = 50; rp = 50; end
      endcase
      for (int i = 0; i < 600; i++) begin
        tick();
        if (!bus.wr_req_i || wg) begin
          bus.wr_req_i  = ($urandom_range(0, 99) < wp);
          bus.wr_addr_i = AW'($urandom_range(0, 63));
          bus.wr_data_i = PW'($urandom);
        end
        if (!bus.rd_req_i || rg) begin
          bus.rd_req_i  = ($urandom_range(0, 99) < rp);
          bus.rd_addr_i = AW'($urandom_range(0, 63));
        end
        @(negedge clk);
        wg = bus.wr_gnt_o;
        rg = bus.rd_gnt_o;
      end
    end
    tick();
    idle_reqs();
    repeat (8) @(negedge clk);
    check("drain_reads", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_mem_arbiter.md
# sobel_mem_arbiter

Single-port frame-RAM arbiter between the grayscale writer, which stores converted pixels, and the Sobel window reader, which fetches the 9 pixels of each 3x3 kernel. It issues at most one memory access per cycle. Consecutive accesses from one owner form a burst, so a full kernel window is fetched without interruption, and ownership alternates round-robin between the two requesters. It sits between the preprocessing front end, the Sobel controller and the frame buffer RAM.

## Interface
- ADDR_WIDTH, 15, frame RAM address width (160x120 frame)
- PIXEL_WIDTH, 8, pixel data width
- MAX_BURST, 9, maximum consecutive grants to one owner while the other requests; legal range 1..15
- clk_i  in  1  clock
- nreset_i  in  1  reset, asynchronous, active-low
- wr_req_i  in  1  writer requests one write this cycle
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  PIXEL_WIDTH  write pixel
- wr_gnt_o  out  1  write accepted this cycle (combinational)
- rd_req_i  in  1  reader requests one read this cycle
- rd_addr_i  in  ADDR_WIDTH  read address
- rd_gnt_o  out  1  read accepted this cycle (combinational)
- rd_data_o  out  PIXEL_WIDTH  returned pixel
- rd_valid_o  out  1  rd_data_o valid, one pulse per accepted read
- mem_en_o  out  1  RAM access enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_WIDTH  RAM address
- mem_wdata_o  out  PIXEL_WIDTH  RAM write data
- mem_rdata_i  in  PIXEL_WIDTH  RAM read data; synchronous RAM, valid the cycle after mem_en_o
- busy_o  out  1  high while state is not IDLE

## Operation
- **States:** IDLE, OWN_WR, OWN_RD. The block also keeps a 4-bit burst_cnt and a last_owner flag.
- **IDLE:**
  - Only one request is high: grant it, go to that owner's OWN state, burst_cnt=1.
  - Both requests are high: the requester that is not last_owner wins.
  - No request: stay in IDLE.
- **OWN_X, continue:** req_X high and (burst_cnt<MAX_BURST or other request low): grant X.
  - burst_cnt increments.
  - When the owner continues uncontested at MAX_BURST, burst_cnt reloads to 1.
- **OWN_X, switch:** req_X low, or burst_cnt==MAX_BURST with the other request high.
  - Other request high: grant the other in the same cycle, move to its OWN state, burst_cnt=1. There is no bubble.
  - Otherwise: no grant, go to IDLE.
- **last_owner** updates to the owner of every grant.
- **Grant properties:** wr_gnt_o and rd_gnt_o are never high together. A requester holds its address and data until granted. A grant consumes exactly one access.
- **Memory port:** outputs are registered from the grant.
  - mem_en_o = any grant.
  - mem_we_o = wr_gnt.
  - mem_addr_o and mem_wdata_o come from the granted port.
  - On no grant, mem_en_o=0 and mem_we_o=0; address and data hold their previous values.
- **Read return:** rd_data_o is registered mem_rdata_i. rd_valid_o is rd_gnt delayed by 3 cycles. Read data returns in grant order.

## Timing
- A grant in cycle T drives the RAM access in T+1.
  - Writes complete at the end of T+1.
  - Reads present rd_data_o/rd_valid_o in T+3.
- **Throughput:** 1 access per cycle, including on owner switches.
- **Reset values:**
  - All outputs 0.
  - state=IDLE, burst_cnt=0, last_owner=RD, so a write wins the first contention.
- **Reset mid-operation:** in-flight reads are discarded; rd_valid_o does not pulse for them after reset release.
- **Simultaneous events:** a request arriving in the same cycle the owner drops its request is granted that cycle.
- **Worst-case wait:** a requester waits at most MAX_BURST cycles after contention begins.

## Configuration
- **SOBEL_ARB_RD_PRIORITY_EN defined:**
  - Reads win every IDLE contention.
  - OWN_RD ignores the burst limit while rd_req_i stays high; writes wait until reads stop.
  - OWN_WR still yields after MAX_BURST.
- **Undefined:** round-robin and a symmetric burst limit as described above.

## Test plan
- **Single write:** wr_req_i=1, addr=0x0042, data=0xA5, one cycle.
  - Required: wr_gnt_o same cycle; next cycle mem_en_o=1, mem_we_o=1, mem_addr_o=0x0042, mem_wdata_o=0xA5.
- **Single read:** read of 0x0100 with the RAM model returning 0x3C.
  - Required: rd_valid_o=1 with rd_data_o=0x3C exactly 3 cycles after rd_gnt_o.
- **Contention after reset:** both requests high in the first cycle.
  - Required: write granted first; with both held and MAX_BURST=9, grants are 9 writes then 9 reads, with no idle cycle.
- **Burst hold:** 9-read window burst with a write raised at read 3.
  - Required: reads 1-9 uninterrupted, write granted in the 10th cycle, 9 rd_valid_o pulses in order.
- **Reset mid-burst:** nreset_i low after 4 read grants.
  - Required: all outputs 0 immediately, no rd_valid_o pulses after release, first contention goes to the write.
- **Macro variant:** with SOBEL_ARB_RD_PRIORITY_EN, continuous reads for 20 cycles and a write pending.
  - Required: write granted only in the cycle after rd_req_i drops.
